// File: rtl/prim_dom_and_nshare.sv
// Domain-oriented masked AND (GF(2) multiply) over NumShares shares with valid/ready on both sides.
// Inner and cross-domain terms are registered in one stage; an optional output register adds a second.
module prim_dom_and_nshare #(
  parameter int  DW        = 64,
  parameter int  NumShares = 2,
  parameter bit  OutReg    = 1'b0,
  localparam int NumZ      = NumShares * (NumShares - 1) / 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [NumShares*DW-1:0] a_i,
  input  logic [NumShares*DW-1:0] b_i,
  input  logic [NumZ*DW-1:0]      z_i,
  input  logic                    z_valid_i,
  output logic                    z_ack_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [NumShares*DW-1:0] q_o
);

  if (NumShares < 2 || NumShares > 4) begin : g_bad_shares
    $error("prim_dom_and_nshare: NumShares must be in 2..4");
  end

  typedef logic [NumShares-1:0][DW-1:0] shares_t;

  function automatic logic [DW-1:0] unmask(input shares_t s);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NumShares; i++) r ^= s[i];
    return r;
  endfunction

  shares_t a_s, b_s, q_c;
  logic [NumShares-1:0][NumShares-1:0][DW-1:0] prod, t_d, t_q;
  logic acc, v1_q, v1_d;
  logic [DW-1:0] exp1_q, exp_out;

  assign a_s     = a_i;
  assign b_s     = b_i;
  assign acc     = valid_i & z_valid_i & ready_o;
  assign z_ack_o = acc;

  // Products are formed first; the cross-domain XOR with fresh z lands straight in the register.
  for (genvar i = 0; i < NumShares; i++) begin : g_row
    for (genvar j = 0; j < NumShares; j++) begin : g_col
      localparam int Lo = (i < j) ? i : j;
      localparam int Hi = (i < j) ? j : i;
      localparam int K  = Lo + Hi * (Hi - 1) / 2;
      assign prod[i][j] = a_s[i] & b_s[j];
      if (i == j) begin : g_inner
        assign t_d[i][j] = prod[i][j];
      end else begin : g_cross
        assign t_d[i][j] = prod[i][j] ^ z_i[K*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_q    <= '0;
      v1_q   <= 1'b0;
      exp1_q <= '0;
    end else begin
      v1_q <= v1_d;
      if (acc) begin
        t_q    <= t_d;
        exp1_q <= unmask(a_s) & unmask(b_s);
      end
    end
  end

  always_comb begin
    q_c = '0;
    for (int i = 0; i < NumShares; i++)
      for (int j = 0; j < NumShares; j++)
        q_c[i] ^= t_q[i][j];
  end

  if (OutReg) begin : g_oreg
    shares_t       q2_q;
    logic          v2_q, s2_rdy, mv;
    logic [DW-1:0] exp2_q;

    assign s2_rdy  = !v2_q | ready_i;
    assign mv      = v1_q & s2_rdy;
    assign ready_o = !v1_q | s2_rdy;
    assign v1_d    = acc | (v1_q & !mv);
    assign valid_o = v2_q;
    assign q_o     = q2_q;
    assign exp_out = exp2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q2_q   <= '0;
        v2_q   <= 1'b0;
        exp2_q <= '0;
      end else begin
        v2_q <= mv | (v2_q & !ready_i);
        if (mv) begin
          q2_q   <= q_c;
          exp2_q <= exp1_q;
        end
      end
    end
  end else begin : g_noreg
    assign ready_o = !v1_q | ready_i;
    assign v1_d    = acc | (v1_q & !ready_i);
    assign valid_o = v1_q;
    assign q_o     = q_c;
    assign exp_out = exp1_q;
  end

  // exp1_q/exp2_q shadow the unmasked product purely for the equivalence check below.
  a_unmasked_eq : assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o && ready_i |-> unmask(q_o) == exp_out);
  a_q_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o && !ready_i |=> valid_o && $stable(q_o));
  a_z_ack : assert property (@(posedge clk_i) disable iff (!rst_ni)
    z_ack_o |-> z_valid_i);

endmodule

// File: tb/tb_prim_dom_and_nshare.sv
// Directed bench: 2-share/latency-1 instance (p_*) and 3-share/latency-2 instance (t_*).
module tb_prim_dom_and_nshare;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic        p_vi = 0, p_rdy, p_zv = 0, p_zack, p_vo, p_ri = 1;
  logic [15:0] p_a = '0, p_b = '0, p_q;
  logic [7:0]  p_z = '0;
  logic        t_vi = 0, t_rdy, t_zv = 0, t_zack, t_vo, t_ri = 1;
  logic [23:0] t_a = '0, t_b = '0, t_z = '0, t_q;

  prim_dom_and_nshare #(.DW(8), .NumShares(2), .OutReg(1'b0)) u_p (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(p_vi), .ready_o(p_rdy), .a_i(p_a), .b_i(p_b),
    .z_i(p_z), .z_valid_i(p_zv), .z_ack_o(p_zack), .valid_o(p_vo), .ready_i(p_ri), .q_o(p_q));

  prim_dom_and_nshare #(.DW(8), .NumShares(3), .OutReg(1'b1)) u_t (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(t_vi), .ready_o(t_rdy), .a_i(t_a), .b_i(t_b),
    .z_i(t_z), .z_valid_i(t_zv), .z_ack_o(t_zack), .valid_o(t_vo), .ready_i(t_ri), .q_o(t_q));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_p_v1();
    p_a = {8'hF0, 8'h0F}; p_b = {8'h00, 8'h33}; p_z = 8'hA5;
  endtask

  task automatic drive_t_v();
    t_a = {8'hF0, 8'h22, 8'h11}; t_b = {8'h05, 8'h50, 8'h0F}; t_z = {8'h04, 8'h02, 8'h01};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (p_vo !== 1'b0 || p_q !== 16'h0) begin errs++;
      $display("FAIL reset_p_out got vo=%0b q=%h exp vo=0 q=0000", p_vo, p_q); end
    checks++; if (p_rdy !== 1'b1 || p_zack !== 1'b0) begin errs++;
      $display("FAIL reset_p_hs got rdy=%0b zack=%0b exp rdy=1 zack=0", p_rdy, p_zack); end
    checks++; if (t_vo !== 1'b0 || t_q !== 24'h0 || t_rdy !== 1'b1) begin errs++;
      $display("FAIL reset_t got vo=%0b q=%h rdy=%0b exp 0/0/1", t_vo, t_q, t_rdy); end
    step(); rst_n = 1'b1; step();
  endtask

  task automatic test_basic();
    drive_p_v1(); p_vi = 1; p_zv = 1; p_ri = 1;
    #1;
    checks++; if (p_zack !== 1'b1) begin errs++;
      $display("FAIL basic_zack got=%0b exp=1", p_zack); end
    step(); p_vi = 0; p_zv = 0;
    checks++; if (p_vo !== 1'b1 || p_q !== 16'h95A6) begin errs++;
      $display("FAIL basic_q got vo=%0b q=%h exp vo=1 q=95a6", p_vo, p_q); end
    step();
    checks++; if (p_vo !== 1'b0) begin errs++;
      $display("FAIL basic_drain got vo=%0b exp=0", p_vo); end
  endtask

  task automatic test_z_stall();
    drive_p_v1(); p_vi = 1; p_zv = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (p_rdy !== 1'b1 || p_zack !== 1'b0 || p_vo !== 1'b0) begin errs++;
        $display("FAIL zstall_c%0d got rdy=%0b zack=%0b vo=%0b exp 1/0/0", c, p_rdy, p_zack, p_vo); end
      step();
    end
    p_zv = 1;
    #1;
    checks++; if (p_zack !== 1'b1) begin errs++;
      $display("FAIL zstall_ack got=%0b exp=1", p_zack); end
    step(); p_vi = 0; p_zv = 0;
    checks++; if (p_vo !== 1'b1 || p_q !== 16'h95A6) begin errs++;
      $display("FAIL zstall_q got vo=%0b q=%h exp vo=1 q=95a6", p_vo, p_q); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_u;
    int zcnt;
    zcnt = 0;
    p_ri = 1;
    for (int n = 0; n < 16; n++) begin
      p_a = 16'($urandom); p_b = 16'($urandom); p_z = 8'($urandom);
      exp_u = (p_a[15:8] ^ p_a[7:0]) & (p_b[15:8] ^ p_b[7:0]);
      p_vi = 1; p_zv = 1;
      #1;
      if (p_zack === 1'b1) zcnt++;
      step();
      checks++; if (p_vo !== 1'b1 || (p_q[15:8] ^ p_q[7:0]) !== exp_u) begin errs++;
        $display("FAIL b2b_%0d got vo=%0b xor=%h exp vo=1 xor=%h", n, p_vo, p_q[15:8] ^ p_q[7:0], exp_u); end
    end
    p_vi = 0; p_zv = 0;
    checks++; if (zcnt !== 16) begin errs++;
      $display("FAIL b2b_zack_count got=%0d exp=16", zcnt); end
    step();
    checks++; if (p_vo !== 1'b0) begin errs++;
      $display("FAIL b2b_drain got vo=%0b exp=0", p_vo); end
  endtask

  task automatic test_out_stall();
    drive_p_v1(); p_vi = 1; p_zv = 1; p_ri = 1;
    step();
    p_ri = 0;
    p_a = {8'h00, 8'hFF}; p_b = {8'hF0, 8'h0F}; p_z = 8'h3C;
    #1;
    checks++; if (p_rdy !== 1'b0 || p_zack !== 1'b0) begin errs++;
      $display("FAIL ostall_hs got rdy=%0b zack=%0b exp 0/0", p_rdy, p_zack); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (p_vo !== 1'b1 || p_q !== 16'h95A6 || p_zack !== 1'b0 || p_rdy !== 1'b0) begin errs++;
        $display("FAIL ostall_hold_c%0d got vo=%0b q=%h zack=%0b rdy=%0b exp 1/95a6/0/0", c, p_vo, p_q, p_zack, p_rdy); end
    end
    p_ri = 1;
    #1;
    checks++; if (p_rdy !== 1'b1 || p_zack !== 1'b1) begin errs++;
      $display("FAIL ostall_release got rdy=%0b zack=%0b exp 1/1", p_rdy, p_zack); end
    step(); p_vi = 0; p_zv = 0;
    checks++; if (p_vo !== 1'b1 || p_q !== 16'h3CC3) begin errs++;
      $display("FAIL ostall_next got vo=%0b q=%h exp vo=1 q=3cc3", p_vo, p_q); end
    step();
    checks++; if (p_vo !== 1'b0) begin errs++;
      $display("FAIL ostall_drain got vo=%0b exp=0", p_vo); end
  endtask

  task automatic test_three_share();
    drive_t_v(); t_vi = 1; t_zv = 1; t_ri = 1;
    #1;
    checks++; if (t_zack !== 1'b1) begin errs++;
      $display("FAIL ns3_zack got=%0b exp=1", t_zack); end
    step(); t_vi = 0; t_zv = 0;
    checks++; if (t_vo !== 1'b0) begin errs++;
      $display("FAIL ns3_early got vo=%0b exp=0", t_vo); end
    step();
    checks++; if (t_vo !== 1'b1 || t_q !== 24'h560713) begin errs++;
      $display("FAIL ns3_q got vo=%0b q=%h exp vo=1 q=560713", t_vo, t_q); end
    step();
    checks++; if (t_vo !== 1'b0) begin errs++;
      $display("FAIL ns3_drain got vo=%0b exp=0", t_vo); end
  endtask

  task automatic test_reset_mid();
    drive_p_v1(); p_vi = 1; p_zv = 1; p_ri = 0;
    drive_t_v();  t_vi = 1; t_zv = 1; t_ri = 0;
    step(); p_vi = 0; p_zv = 0; t_vi = 0; t_zv = 0;
    step(); step();
    checks++; if (p_vo !== 1'b1 || t_vo !== 1'b1 || t_q !== 24'h560713) begin errs++;
      $display("FAIL rmid_pre got pvo=%0b tvo=%0b tq=%h exp 1/1/560713", p_vo, t_vo, t_q); end
    rst_n = 1'b0;
    #1;
    checks++; if (p_vo !== 1'b0 || p_q !== 16'h0 || p_rdy !== 1'b1) begin errs++;
      $display("FAIL rmid_p got vo=%0b q=%h rdy=%0b exp 0/0000/1", p_vo, p_q, p_rdy); end
    checks++; if (t_vo !== 1'b0 || t_q !== 24'h0 || t_rdy !== 1'b1) begin errs++;
      $display("FAIL rmid_t got vo=%0b q=%h rdy=%0b exp 0/000000/1", t_vo, t_q, t_rdy); end
    step(); rst_n = 1'b1; p_ri = 1; t_ri = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (p_vo !== 1'b0 || t_vo !== 1'b0) begin errs++;
        $display("FAIL rmid_idle_c%0d got pvo=%0b tvo=%0b exp 0/0", c, p_vo, t_vo); end
    end
    drive_p_v1(); p_vi = 1; p_zv = 1;
    step(); p_vi = 0; p_zv = 0;
    checks++; if (p_vo !== 1'b1 || p_q !== 16'h95A6) begin errs++;
      $display("FAIL rmid_new got vo=%0b q=%h exp vo=1 q=95a6", p_vo, p_q); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_z_stall();
    test_back_to_back();
    test_out_stall();
    test_three_share();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
